// File: rtl/age_ordered_rs.sv
// age_ordered_rs: reservation station that snoops several CDB ports and issues the
// oldest entry whose operands are both present, using an age matrix for ordering.
module age_ordered_rs #(
  parameter int RS_SIZE   = 8,
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 4,
  parameter int NUM_CDB   = 2,
  parameter int OP_WIDTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             disp_valid,
  output logic                             disp_ready,
  input  logic [XLEN-1:0]                  disp_src1_val,
  input  logic [TAG_WIDTH-1:0]             disp_src1_tag,
  input  logic                             disp_src1_rdy,
  input  logic [XLEN-1:0]                  disp_src2_val,
  input  logic [TAG_WIDTH-1:0]             disp_src2_tag,
  input  logic                             disp_src2_rdy,
  input  logic [XLEN-1:0]                  disp_imm,
  input  logic [OP_WIDTH-1:0]              disp_op,
  input  logic [TAG_WIDTH-1:0]             disp_dst_tag,
  input  logic [NUM_CDB-1:0]               cdb_valid,
  input  logic [NUM_CDB*TAG_WIDTH-1:0]     cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]          cdb_result,
  output logic                             iss_valid,
  input  logic                             iss_ready,
  output logic [XLEN-1:0]                  iss_op1,
  output logic [XLEN-1:0]                  iss_op2,
  output logic [XLEN-1:0]                  iss_imm,
  output logic [OP_WIDTH-1:0]              iss_op,
  output logic [TAG_WIDTH-1:0]             iss_dst_tag,
  output logic [$clog2(RS_SIZE+1)-1:0]     occupancy
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int OCC_W = $clog2(RS_SIZE + 1);

  // Search all CDB ports for a tag; the lowest-numbered matching port wins.
  // Returns {hit, value}.
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [TAG_WIDTH-1:0]         tag,
    input logic [NUM_CDB-1:0]           vld,
    input logic [NUM_CDB*TAG_WIDTH-1:0] tags,
    input logic [NUM_CDB*XLEN-1:0]      res
  );
    logic [XLEN:0] found;
    found = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (vld[k] && (tags[k*TAG_WIDTH +: TAG_WIDTH] == tag)) begin
        found = {1'b1, res[k*XLEN +: XLEN]};
      end else begin
        found = found;
      end
    end
    return found;
  endfunction

  // Entry storage
  logic [RS_SIZE-1:0]   busy_r;
  logic [RS_SIZE-1:0]   s1_rdy_r;
  logic [RS_SIZE-1:0]   s2_rdy_r;
  logic [XLEN-1:0]      s1_val_r [RS_SIZE];
  logic [XLEN-1:0]      s2_val_r [RS_SIZE];
  logic [XLEN-1:0]      imm_r    [RS_SIZE];
  logic [TAG_WIDTH-1:0] s1_tag_r [RS_SIZE];
  logic [TAG_WIDTH-1:0] s2_tag_r [RS_SIZE];
  logic [TAG_WIDTH-1:0] dst_r    [RS_SIZE];
  logic [OP_WIDTH-1:0]  op_r     [RS_SIZE];
  // older_r[j][i] set means entry j was dispatched before entry i
  logic [RS_SIZE-1:0]   older_r  [RS_SIZE];
  logic                 lock_r;
  logic [IDX_W-1:0]     lock_idx_r;
  logic [OCC_W-1:0]     occ_r;

  // Combinational helpers
  logic [RS_SIZE-1:0]   ready_s;
  logic [RS_SIZE-1:0]   blocked_s;
  logic [IDX_W-1:0]     oldest_idx_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic [IDX_W-1:0]     free_idx_s;
  logic                 iss_valid_s;
  logic                 iss_fire_s;
  logic                 disp_ready_s;
  logic                 disp_accept_s;
  logic [RS_SIZE-1:0]   wk1_hit_s;
  logic [RS_SIZE-1:0]   wk2_hit_s;
  logic [XLEN-1:0]      wk1_val_s [RS_SIZE];
  logic [XLEN-1:0]      wk2_val_s [RS_SIZE];
  logic                 d1_hit_s;
  logic                 d2_hit_s;
  logic [XLEN-1:0]      d1_cdb_s;
  logic [XLEN-1:0]      d2_cdb_s;
  logic                 d1_rdy_s;
  logic                 d2_rdy_s;
  logic [XLEN-1:0]      d1_val_s;
  logic [XLEN-1:0]      d2_val_s;

  // CDB match for every stored source and for the incoming dispatch sources
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      {wk1_hit_s[i], wk1_val_s[i]} = cdb_lookup(s1_tag_r[i], cdb_valid, cdb_tag, cdb_result);
      {wk2_hit_s[i], wk2_val_s[i]} = cdb_lookup(s2_tag_r[i], cdb_valid, cdb_tag, cdb_result);
    end
    {d1_hit_s, d1_cdb_s} = cdb_lookup(disp_src1_tag, cdb_valid, cdb_tag, cdb_result);
    {d2_hit_s, d2_cdb_s} = cdb_lookup(disp_src2_tag, cdb_valid, cdb_tag, cdb_result);
    d1_rdy_s = disp_src1_rdy | d1_hit_s;
    d2_rdy_s = disp_src2_rdy | d2_hit_s;
    d1_val_s = disp_src1_rdy ? disp_src1_val : d1_cdb_s;
    d2_val_s = disp_src2_rdy ? disp_src2_val : d2_cdb_s;
  end

  // Oldest-ready selection, lowest free slot, and handshake qualifiers
  always_comb begin
    ready_s      = busy_r & s1_rdy_r & s2_rdy_r;
    blocked_s    = '0;
    oldest_idx_s = '0;
    free_idx_s   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        blocked_s[i] = blocked_s[i] | (ready_s[j] & older_r[j][i]);
      end
    end
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      oldest_idx_s = (ready_s[i] && !blocked_s[i]) ? IDX_W'(i) : oldest_idx_s;
      free_idx_s   = busy_r[i] ? free_idx_s : IDX_W'(i);
    end
    sel_idx_s     = lock_r ? lock_idx_r : oldest_idx_s;
    iss_valid_s   = !flush && (lock_r || (|ready_s));
    iss_fire_s    = iss_valid_s && iss_ready;
    disp_ready_s  = !(&busy_r);
    disp_accept_s = disp_valid && disp_ready_s && !flush;
  end

  assign disp_ready  = disp_ready_s;
  assign iss_valid   = iss_valid_s;
  assign iss_op1     = s1_val_r[sel_idx_s];
  assign iss_op2     = s2_val_r[sel_idx_s];
  assign iss_imm     = imm_r[sel_idx_s];
  assign iss_op      = op_r[sel_idx_s];
  assign iss_dst_tag = dst_r[sel_idx_s];
  assign occupancy   = occ_r;

  // Entry state: wakeup, issue release, dispatch write, age update, lock and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= '0;
      s1_rdy_r   <= '0;
      s2_rdy_r   <= '0;
      lock_r     <= 1'b0;
      lock_idx_r <= '0;
      occ_r      <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        s1_val_r[i] <= '0;
        s2_val_r[i] <= '0;
        imm_r[i]    <= '0;
        s1_tag_r[i] <= '0;
        s2_tag_r[i] <= '0;
        dst_r[i]    <= '0;
        op_r[i]     <= '0;
        older_r[i]  <= '0;
      end
    end else if (flush) begin
      busy_r <= '0;
      lock_r <= 1'b0;
      occ_r  <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_r[i] && !s1_rdy_r[i] && wk1_hit_s[i]) begin
          s1_rdy_r[i] <= 1'b1;
          s1_val_r[i] <= wk1_val_s[i];
        end
        if (busy_r[i] && !s2_rdy_r[i] && wk2_hit_s[i]) begin
          s2_rdy_r[i] <= 1'b1;
          s2_val_r[i] <= wk2_val_s[i];
        end
      end
      if (iss_fire_s) begin
        busy_r[sel_idx_s] <= 1'b0;
      end
      if (disp_accept_s) begin
        busy_r[free_idx_s]   <= 1'b1;
        s1_rdy_r[free_idx_s] <= d1_rdy_s;
        s2_rdy_r[free_idx_s] <= d2_rdy_s;
        s1_val_r[free_idx_s] <= d1_val_s;
        s2_val_r[free_idx_s] <= d2_val_s;
        s1_tag_r[free_idx_s] <= disp_src1_tag;
        s2_tag_r[free_idx_s] <= disp_src2_tag;
        imm_r[free_idx_s]    <= disp_imm;
        op_r[free_idx_s]     <= disp_op;
        dst_r[free_idx_s]    <= disp_dst_tag;
        // New entry is younger than every entry currently held
        older_r[free_idx_s]  <= '0;
        for (int j = 0; j < RS_SIZE; j++) begin
          older_r[j][free_idx_s] <= busy_r[j];
        end
      end
      if (iss_fire_s) begin
        lock_r <= 1'b0;
      end else if (iss_valid_s) begin
        lock_r     <= 1'b1;
        lock_idx_r <= sel_idx_s;
      end else begin
        lock_r <= lock_r;
      end
      occ_r <= occ_r + OCC_W'(disp_accept_s) - OCC_W'(iss_fire_s);
    end
  end

endmodule

// File: tb/tb_age_ordered_rs.sv
// tb_age_ordered_rs: directed scenarios plus a randomized run against an in-order
// queue model of the reservation station.
module tb_age_ordered_rs;

  localparam int RS = 8;
  localparam int XL = 32;
  localparam int TW = 4;
  localparam int NC = 2;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          disp_valid = 1'b0;
  logic          disp_ready;
  logic [XL-1:0] disp_src1_val = '0;
  logic [TW-1:0] disp_src1_tag = '0;
  logic          disp_src1_rdy = 1'b0;
  logic [XL-1:0] disp_src2_val = '0;
  logic [TW-1:0] disp_src2_tag = '0;
  logic          disp_src2_rdy = 1'b0;
  logic [XL-1:0] disp_imm = '0;
  logic [OW-1:0] disp_op = '0;
  logic [TW-1:0] disp_dst_tag = '0;
  logic [NC-1:0] cdb_valid = '0;
  logic [NC*TW-1:0] cdb_tag = '0;
  logic [NC*XL-1:0] cdb_result = '0;
  logic          iss_valid;
  logic          iss_ready = 1'b0;
  logic [XL-1:0] iss_op1, iss_op2, iss_imm;
  logic [OW-1:0] iss_op;
  logic [TW-1:0] iss_dst_tag;
  logic [3:0]    occupancy;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    int          id;
    logic        r1;
    logic        r2;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [3:0]  t1;
    logic [3:0]  t2;
    logic [3:0]  op;
    logic [3:0]  dst;
  } ent_t;

  age_ordered_rs #(.RS_SIZE(RS), .XLEN(XL), .TAG_WIDTH(TW), .NUM_CDB(NC), .OP_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_src1_val(disp_src1_val), .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
    .disp_src2_val(disp_src2_val), .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy),
    .disp_imm(disp_imm), .disp_op(disp_op), .disp_dst_tag(disp_dst_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_op1(iss_op1), .iss_op2(iss_op2), .iss_imm(iss_imm),
    .iss_op(iss_op), .iss_dst_tag(iss_dst_tag), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task idle();
    disp_valid = 1'b0;
    flush      = 1'b0;
    cdb_valid  = '0;
  endtask

  task disp(input logic [31:0] v1, input logic [3:0] t1, input logic r1,
            input logic [31:0] v2, input logic [3:0] t2, input logic r2, input logic [3:0] dst);
    disp_valid    = 1'b1;
    disp_src1_val = v1; disp_src1_tag = t1; disp_src1_rdy = r1;
    disp_src2_val = v2; disp_src2_tag = t2; disp_src2_rdy = r2;
    disp_imm      = 32'h100 + {28'h0, dst};
    disp_op       = dst;
    disp_dst_tag  = dst;
  endtask

  task cdb(input int k, input logic [3:0] t, input logic [31:0] r);
    cdb_valid[k]            = 1'b1;
    cdb_tag[k*TW +: TW]     = t;
    cdb_result[k*XL +: XL]  = r;
  endtask

  // Reference lookup: first valid CDB port (ascending) carrying the tag
  function automatic logic [32:0] m_lookup(input logic [3:0] t);
    for (int k = 0; k < NC; k++) begin
      if (cdb_valid[k] && cdb_tag[k*TW +: TW] == t) return {1'b1, cdb_result[k*XL +: XL]};
    end
    return 33'h0;
  endfunction

  task test_reset();
    #1;
    n_chk++;
    if ({iss_valid, disp_ready, occupancy} !== {1'b0, 1'b1, 4'd0}) begin
      n_fail++; $display("FAIL reset: got %b exp %b", {iss_valid, disp_ready, occupancy}, 6'b010000);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_chk++;
    if ({iss_valid, disp_ready, occupancy} !== {1'b0, 1'b1, 4'd0}) begin
      n_fail++; $display("FAIL reset_release: got %b exp %b", {iss_valid, disp_ready, occupancy}, 6'b010000);
    end
  endtask

  task test_basic_issue();
    @(negedge clk); idle(); iss_ready = 1'b1; disp(32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 1'b1, 4'd3); #1;
    n_chk++;
    if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty: got %b exp 0", iss_valid); end
    @(negedge clk); idle(); #1;
    n_chk++;
    if ({iss_valid, iss_op1, iss_op2, iss_imm, iss_op, iss_dst_tag, occupancy} !==
        {1'b1, 32'd5, 32'd7, 32'h103, 4'd3, 4'd3, 4'd1}) begin
      n_fail++; $display("FAIL basic_issue: got v=%b op1=%0d op2=%0d imm=%h op=%0d dst=%0d occ=%0d exp 1/5/7/103/3/3/1",
                         iss_valid, iss_op1, iss_op2, iss_imm, iss_op, iss_dst_tag, occupancy);
    end
    @(negedge clk); #1;
    n_chk++;
    if ({iss_valid, occupancy} !== {1'b0, 4'd0}) begin
      n_fail++; $display("FAIL basic_drain: got v=%b occ=%0d exp 0/0", iss_valid, occupancy);
    end
  endtask

  task test_wakeup_order();
    @(negedge clk); idle(); iss_ready = 1'b1; disp(32'd0, 4'd2, 1'b0, 32'h21, 4'd0, 1'b1, 4'd5); #1;
    @(negedge clk); idle(); disp(32'h11, 4'd0, 1'b1, 32'h22, 4'd0, 1'b1, 4'd6); #1;
    n_chk++;
    if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL wake_pending: got %b exp 0", iss_valid); end
    @(negedge clk); idle(); cdb(0, 4'd2, 32'h55); #1;
    n_chk++;
    if ({iss_valid, iss_dst_tag} !== {1'b1, 4'd6}) begin
      n_fail++; $display("FAIL wake_b_first: got v=%b dst=%0d exp 1/6", iss_valid, iss_dst_tag);
    end
    @(negedge clk); idle(); #1;
    n_chk++;
    if ({iss_valid, iss_dst_tag, iss_op1, iss_op2} !== {1'b1, 4'd5, 32'h55, 32'h21}) begin
      n_fail++; $display("FAIL wake_a_next: got v=%b dst=%0d op1=%h op2=%h exp 1/5/55/21",
                         iss_valid, iss_dst_tag, iss_op1, iss_op2);
    end
    @(negedge clk); #1;
    n_chk++;
    if ({iss_valid, occupancy} !== {1'b0, 4'd0}) begin
      n_fail++; $display("FAIL wake_drain: got v=%b occ=%0d exp 0/0", iss_valid, occupancy);
    end
  endtask

  task test_dispatch_snoop();
    @(negedge clk); idle(); iss_ready = 1'b1; disp(32'd0, 4'd6, 1'b0, 32'h3, 4'd0, 1'b1, 4'd9);
    cdb(0, 4'd6, 32'h60); cdb(1, 4'd6, 32'h66); #1;
    @(negedge clk); idle(); #1;
    n_chk++;
    if ({iss_valid, iss_dst_tag, iss_op1} !== {1'b1, 4'd9, 32'h60}) begin
      n_fail++; $display("FAIL snoop_lowport: got v=%b dst=%0d op1=%h exp 1/9/60", iss_valid, iss_dst_tag, iss_op1);
    end
    @(negedge clk); #1;
  endtask

  task test_multi_cdb();
    @(negedge clk); idle(); iss_ready = 1'b0; disp(32'd0, 4'd1, 1'b0, 32'h2, 4'd0, 1'b1, 4'd7); #1;
    @(negedge clk); idle(); disp(32'h3, 4'd0, 1'b1, 32'd0, 4'd4, 1'b0, 4'd8); #1;
    @(negedge clk); idle(); cdb(0, 4'd1, 32'hA); cdb(1, 4'd4, 32'hB); #1;
    n_chk++;
    if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL mcdb_pending: got %b exp 0", iss_valid); end
    @(negedge clk); idle(); iss_ready = 1'b1; #1;
    n_chk++;
    if ({iss_valid, iss_dst_tag, iss_op1} !== {1'b1, 4'd7, 32'hA}) begin
      n_fail++; $display("FAIL mcdb_first: got v=%b dst=%0d op1=%h exp 1/7/a", iss_valid, iss_dst_tag, iss_op1);
    end
    @(negedge clk); #1;
    n_chk++;
    if ({iss_valid, iss_dst_tag, iss_op2} !== {1'b1, 4'd8, 32'hB}) begin
      n_fail++; $display("FAIL mcdb_second: got v=%b dst=%0d op2=%h exp 1/8/b", iss_valid, iss_dst_tag, iss_op2);
    end
    @(negedge clk); #1;
  endtask

  task test_full();
    iss_ready = 1'b0;
    for (int k = 0; k < RS; k++) begin
      @(negedge clk); idle(); disp(32'(k) + 32'h40, 4'd0, 1'b1, 32'h1, 4'd0, 1'b1, 4'(k));
    end
    @(negedge clk); idle(); disp(32'h99, 4'd0, 1'b1, 32'h1, 4'd0, 1'b1, 4'd15); #1;
    n_chk++;
    if ({disp_ready, occupancy, iss_valid, iss_dst_tag} !== {1'b0, 4'd8, 1'b1, 4'd0}) begin
      n_fail++; $display("FAIL full: got rdy=%b occ=%0d v=%b dst=%0d exp 0/8/1/0", disp_ready, occupancy, iss_valid, iss_dst_tag);
    end
    @(negedge clk); idle(); iss_ready = 1'b1; #1;
    n_chk++;
    if (occupancy !== 4'd8) begin n_fail++; $display("FAIL full_drop: got occ=%0d exp 8", occupancy); end
    @(negedge clk); iss_ready = 1'b0; #1;
    n_chk++;
    if ({disp_ready, occupancy} !== {1'b1, 4'd7}) begin
      n_fail++; $display("FAIL full_one_free: got rdy=%b occ=%0d exp 1/7", disp_ready, occupancy);
    end
    for (int k = 1; k < RS; k++) begin
      @(negedge clk); iss_ready = 1'b1; #1;
      n_chk++;
      if ({iss_valid, iss_dst_tag} !== {1'b1, 4'(k)}) begin
        n_fail++; $display("FAIL full_order: got v=%b dst=%0d exp 1/%0d", iss_valid, iss_dst_tag, k);
      end
    end
    @(negedge clk); #1;
    n_chk++;
    if ({iss_valid, occupancy} !== {1'b0, 4'd0}) begin
      n_fail++; $display("FAIL full_drain: got v=%b occ=%0d exp 0/0", iss_valid, occupancy);
    end
  endtask

  task test_lock();
    @(negedge clk); idle(); iss_ready = 1'b0; disp(32'd0, 4'd9, 1'b0, 32'h2, 4'd0, 1'b1, 4'd10);
    @(negedge clk); idle(); disp(32'h77, 4'd0, 1'b1, 32'h1, 4'd0, 1'b1, 4'd11);
    @(negedge clk); idle(); cdb(0, 4'd9, 32'h99); #1;
    n_chk++;
    if ({iss_valid, iss_dst_tag, iss_op1} !== {1'b1, 4'd11, 32'h77}) begin
      n_fail++; $display("FAIL lock_sel: got v=%b dst=%0d op1=%h exp 1/11/77", iss_valid, iss_dst_tag, iss_op1);
    end
    @(negedge clk); idle(); #1;
    n_chk++;
    if ({iss_valid, iss_dst_tag, iss_op1} !== {1'b1, 4'd11, 32'h77}) begin
      n_fail++; $display("FAIL lock_hold: got v=%b dst=%0d op1=%h exp 1/11/77", iss_valid, iss_dst_tag, iss_op1);
    end
    @(negedge clk); iss_ready = 1'b1; #1;
    n_chk++;
    if ({iss_valid, iss_dst_tag} !== {1'b1, 4'd11}) begin
      n_fail++; $display("FAIL lock_accept: got v=%b dst=%0d exp 1/11", iss_valid, iss_dst_tag);
    end
    @(negedge clk); #1;
    n_chk++;
    if ({iss_valid, iss_dst_tag, iss_op1} !== {1'b1, 4'd10, 32'h99}) begin
      n_fail++; $display("FAIL lock_next: got v=%b dst=%0d op1=%h exp 1/10/99", iss_valid, iss_dst_tag, iss_op1);
    end
    @(negedge clk); #1;
  endtask

  task test_flush();
    iss_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); idle(); disp(32'(k), 4'd0, 1'b1, 32'h1, 4'd0, 1'b1, 4'(k));
    end
    @(negedge clk); idle(); flush = 1'b1; disp(32'h5, 4'd0, 1'b1, 32'h6, 4'd0, 1'b1, 4'd12); #1;
    n_chk++;
    if ({iss_valid, occupancy} !== {1'b0, 4'd5}) begin
      n_fail++; $display("FAIL flush_cycle: got v=%b occ=%0d exp 0/5", iss_valid, occupancy);
    end
    @(negedge clk); idle(); #1;
    n_chk++;
    if ({disp_ready, occupancy, iss_valid} !== {1'b1, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL flush_after: got rdy=%b occ=%0d v=%b exp 1/0/0", disp_ready, occupancy, iss_valid);
    end
    @(negedge clk); iss_ready = 1'b1; #1;
    n_chk++;
    if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %b exp 0", iss_valid); end
  endtask

  task test_reset_midop();
    @(negedge clk); idle(); iss_ready = 1'b0; disp(32'h1, 4'd0, 1'b1, 32'h2, 4'd0, 1'b1, 4'd1);
    @(negedge clk); idle(); disp(32'h3, 4'd0, 1'b1, 32'h4, 4'd0, 1'b1, 4'd2);
    @(negedge clk); idle(); #2 rst_n = 1'b0; #1;
    n_chk++;
    if ({iss_valid, disp_ready, occupancy} !== {1'b0, 1'b1, 4'd0}) begin
      n_fail++; $display("FAIL reset_midop: got v=%b rdy=%b occ=%0d exp 0/1/0", iss_valid, disp_ready, occupancy);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task test_random();
    ent_t q[$];
    ent_t e;
    int lock_id, next_id, sel;
    logic exp_v, exp_rdy, can_disp;
    logic [32:0] h;
    lock_id = -1; next_id = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      flush         = ($urandom_range(0, 49) == 0);
      disp_valid    = ($urandom_range(0, 9) < 6);
      disp_src1_val = $urandom; disp_src1_tag = 4'($urandom_range(0, 7)); disp_src1_rdy = ($urandom_range(0, 9) < 4);
      disp_src2_val = $urandom; disp_src2_tag = 4'($urandom_range(0, 7)); disp_src2_rdy = ($urandom_range(0, 9) < 4);
      disp_imm      = $urandom; disp_op = 4'($urandom); disp_dst_tag = 4'($urandom);
      iss_ready     = ($urandom_range(0, 9) < 6);
      for (int k = 0; k < NC; k++) begin
        cdb_valid[k]           = $urandom_range(0, 1) == 1;
        cdb_tag[k*TW +: TW]    = 4'($urandom_range(0, 7));
        cdb_result[k*XL +: XL] = $urandom;
      end
      #1;
      sel = -1;
      for (int i = 0; i < q.size(); i++) begin
        if (lock_id >= 0) begin
          if (q[i].id == lock_id) sel = i;
        end else if (sel < 0 && q[i].r1 && q[i].r2) begin
          sel = i;
        end
      end
      exp_v   = !flush && (sel >= 0);
      exp_rdy = (q.size() < RS);
      n_chk++;
      if ({disp_ready, occupancy} !== {exp_rdy, 4'(q.size())}) begin
        n_fail++; $display("FAIL rand_occ cyc %0d: got rdy=%b occ=%0d exp %b/%0d", cyc, disp_ready, occupancy, exp_rdy, q.size());
      end
      n_chk++;
      if (iss_valid !== exp_v) begin
        n_fail++; $display("FAIL rand_valid cyc %0d: got %b exp %b", cyc, iss_valid, exp_v);
      end
      if (exp_v) begin
        n_chk++;
        if ({iss_op1, iss_op2, iss_imm, iss_op, iss_dst_tag} !== {q[sel].v1, q[sel].v2, q[sel].imm, q[sel].op, q[sel].dst}) begin
          n_fail++; $display("FAIL rand_payload cyc %0d: got %h/%h/%h/%h/%h exp %h/%h/%h/%h/%h", cyc,
                             iss_op1, iss_op2, iss_imm, iss_op, iss_dst_tag,
                             q[sel].v1, q[sel].v2, q[sel].imm, q[sel].op, q[sel].dst);
        end
      end
      if (flush) begin
        q.delete(); lock_id = -1;
      end else begin
        can_disp = (q.size() < RS);
        if (exp_v && iss_ready) begin
          q.delete(sel); lock_id = -1;
        end else if (exp_v) begin
          lock_id = q[sel].id;
        end
        for (int i = 0; i < q.size(); i++) begin
          e = q[i];
          if (!e.r1) begin h = m_lookup(e.t1); if (h[32]) begin e.r1 = 1'b1; e.v1 = h[31:0]; end end
          if (!e.r2) begin h = m_lookup(e.t2); if (h[32]) begin e.r2 = 1'b1; e.v2 = h[31:0]; end end
          q[i] = e;
        end
        if (disp_valid && can_disp) begin
          e.id = next_id; next_id++;
          e.t1 = disp_src1_tag; e.t2 = disp_src2_tag;
          e.r1 = disp_src1_rdy; e.v1 = disp_src1_val;
          e.r2 = disp_src2_rdy; e.v2 = disp_src2_val;
          if (!e.r1) begin h = m_lookup(e.t1); e.r1 = h[32]; e.v1 = h[31:0]; end
          if (!e.r2) begin h = m_lookup(e.t2); e.r2 = h[32]; e.v2 = h[31:0]; end
          e.imm = disp_imm; e.op = disp_op; e.dst = disp_dst_tag;
          q.push_back(e);
        end
      end
    end
    @(negedge clk); idle();
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_wakeup_order();
    test_dispatch_snoop();
    test_multi_cdb();
    test_full();
    test_lock();
    test_flush();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
